// File: rtl/prewitt_pkg.sv
// Shared types for the Prewitt datapath.
// Pixel width, pixel type and window-generator FSM states.
package prewitt_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    FILL,
    STREAM
  } state_t;

endpackage

// File: rtl/prewitt_window_gen_if.sv
// Pixel stream in, 3x3 window out.
// master drives pixels, slave is the window generator.
interface prewitt_window_gen_if;
  import prewitt_pkg::*;

  pixel_t pix_in;
  logic   pix_valid;
  logic   sof;
  pixel_t p1, p2, p3;
  pixel_t p4, p5, p6;
  pixel_t p7, p8, p9;
  logic   win_valid;
  logic   frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  p1, p2, p3, p4, p5, p6,
    input  p7, p8, p9,
    input  win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p1, p2, p3, p4, p5, p6,
    output p7, p8, p9,
    output win_valid, frame_done
  );

endinterface

// File: rtl/prewitt_line_buffer.sv
// One image row of pixel storage.
// Async read of the old word, write on the clock edge.
module prewitt_line_buffer
  import prewitt_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/prewitt_window_gen.sv
// Streaming 3x3 window generator.
// Two line buffers feed the right column of a shifting register window.
module prewitt_window_gen
  import prewitt_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic clk,
  input  logic rst,
  prewitt_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  state_t        state_q, state_d, cur_st;
  logic          acc, last_px;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  pixel_t        lb0_rd, lb1_rd;
  pixel_t        win_q [9];

  // sof restarts the frame at (0,0) for the pixel it qualifies
  always_comb begin
    acc          = bus.pix_valid;
    cur_col      = bus.sof ? '0 : col_q;
    cur_row      = bus.sof ? '0 : row_q;
    cur_st       = bus.sof ? FILL : state_q;
    last_px      = (cur_row == ROW_LAST) &&
                   (cur_col == COL_LAST);
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (acc) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = last_px ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      unique case (cur_st)
        FILL: begin
          if (cur_row == RW'(1) &&
              cur_col == COL_LAST) begin
            state_d = STREAM;
          end else begin
            state_d = FILL;
          end
        end
        STREAM: begin
          state_d = last_px ? FILL : STREAM;
        end
      endcase
      win_valid_d  = (cur_st == STREAM) &&
                     (cur_col >= CW'(2));
      frame_done_d = last_px;
    end
  end

  prewitt_line_buffer #(
    .DEPTH (IMG_W)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (acc && !rst),
    .addr_i  (cur_col),
    .wdata_i (bus.pix_in),
    .rdata_o (lb1_rd)
  );

  prewitt_line_buffer #(
    .DEPTH (IMG_W)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (acc && !rst),
    .addr_i  (cur_col),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= FILL;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]   <= win_q[3*r+1];
          win_q[3*r+1] <= win_q[3*r+2];
        end
        win_q[2] <= lb0_rd;
        win_q[5] <= lb1_rd;
        win_q[8] <= bus.pix_in;
      end
    end
  end

  assign bus.p1         = win_q[0];
  assign bus.p2         = win_q[1];
  assign bus.p3         = win_q[2];
  assign bus.p4         = win_q[3];
  assign bus.p5         = win_q[4];
  assign bus.p6         = win_q[5];
  assign bus.p7         = win_q[6];
  assign bus.p8         = win_q[7];
  assign bus.p9         = win_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
